wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, the number of ALU result buffer entries (power of two, >=2).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit, reset: asynchronous, active-high (reset asserted while rstn=1).
REQ-004 SHALL have alu_valid_i (in, 1), alu_ready_o (out, 1), alu_addr_i (in, 5) and alu_data_i (in, 32), the ALU result push handshake.
REQ-005 SHALL have lsu_valid_i (in, 1), lsu_addr_i (in, 5), lsu_data_i (in, 32), lsu_size_i (in, 2: 00 byte, 01 half, 10 word), lsu_sign_i (in, 1) and lsu_offset_i (in, 2), the load return with no back-pressure.
REQ-006 SHALL have wen_o (out, 1), wr_addr_o (out, 5) and wr_data_o (out, 32), driving the register file write port.
REQ-007 SHALL have hz_addr_i (in, 5) and hz_hit_o (out, 1), a hazard query to the decode stage.

Function
REQ-008 SHALL accept an ALU push in a cycle where alu_valid_i=1 and alu_ready_o=1.
REQ-009 SHALL drive alu_ready_o = not FIFO full, independent of any same-cycle pop; a full FIFO SHALL block a push even while popping.
REQ-010 SHALL accept every cycle with lsu_valid_i=1; LSU SHALL have strict priority over ALU for the write port.
REQ-011 SHALL select per cycle: LSU if valid; else the FIFO head if non-empty; else an accepted ALU push, bypassing the FIFO when it is empty.
REQ-012 SHALL register the selected write, giving 1-cycle latency: selected in cycle N -> wen_o=1 with address/data in cycle N+1, held for exactly one cycle.
REQ-013 SHALL enqueue an accepted ALU push that is not selected (LSU valid, or FIFO non-empty) at the FIFO tail, preserving order.
REQ-014 SHALL handle push and pop in one cycle with count unchanged, pointers wrapping modulo FIFO_DEPTH.
REQ-015 SHALL consume writes with address 0 normally but output them with wen_o=0.
REQ-016 SHALL format load data: word passes lsu_data_i through; half selects bits [31:16] if lsu_offset_i[1]=1 else [15:0]; byte selects lane lsu_offset_i; result sign-extended if lsu_sign_i=1, else zero-extended.
REQ-017 SHALL treat lsu_size_i=11 as word.
REQ-018 SHALL assert hz_hit_o combinationally when hz_addr_i!=0 and matches any valid FIFO entry or the output register with wen_o=1.
REQ-019 SHALL rely on upstream never issuing two in-flight writes to the same non-zero rd (decode stalls on hz_hit_o); same-rd ordering between paths is not otherwise guaranteed.

Reset
REQ-020 SHALL, while rstn=1, force wen_o=0, wr_addr_o=0, wr_data_o=0, alu_ready_o=0 and hz_hit_o=0, and empty the FIFO.
REQ-021 SHALL, on reset assertion mid-operation, discard all buffered and in-flight writes with no wen_o pulse.
REQ-022 SHALL have alu_ready_o=1 in the first cycle after reset release.

Structure
REQ-023 SHALL take RegBus, RegAddrBus, ZeroRegAddr and the load size codes (LS_BYTE, LS_HALF, LS_WORD) from the shared defines file.
REQ-024 SHALL implement load formatting as a combinational sub-module wb_ldfmt.
REQ-025 SHALL keep the FIFO inline in wb_arbiter.

Verification
REQ-026 SHALL test an ALU push (addr 5, 0x12345678) with FIFO empty and LSU idle -> next cycle wen_o=1, wr_addr_o=5, wr_data_o=0x12345678.
REQ-027 SHALL test LSU (addr 3, data 0x000080FF, size byte, offset 0, sign 1) with a same-cycle ALU push (addr 7, 0xA) -> cycle+1 writes x3=0xFFFFFFFF, cycle+2 writes x7=0xA.
REQ-028 SHALL test 4 back-to-back LSU returns with continuous ALU pushes -> alu_ready_o=0 after 2 buffered; ALU writes drain in order after LSU stops; no loss or duplication.
REQ-029 SHALL test an ALU push to addr 0 -> accepted, wen_o stays 0; hz_addr_i=0 -> hz_hit_o=0.
REQ-030 SHALL test a half load (data 0xBEEF1234, offset 2, sign 0) -> wr_data_o=0x0000BEEF.
REQ-031 SHALL test reset asserted with FIFO holding 2 entries -> FIFO emptied, no wen_o pulse after release, alu_ready_o=1 one cycle after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: register file bus widths,
// the hard-wired zero register address and the load size encodings.
package wb_arbiter_pkg;

   typedef logic [31:0] RegBus;
   typedef logic [4:0]  RegAddrBus;

   localparam RegAddrBus ZeroRegAddr = 5'd0;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   // One register file write: destination plus value.
   typedef struct packed {
      RegAddrBus addr;
      RegBus     data;
   } wr_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the execute/memory stages and the writeback arbiter.
//
// Handshake: the ALU push transfers in a cycle where alu_valid_i=1 and
// alu_ready_o=1; while valid is high and ready is low the source holds
// addr/data stable. The LSU return has no ready: every cycle with
// lsu_valid_i=1 is a transfer. The write port and hazard outputs are
// plain level signals with no handshake.
interface wb_arbiter_if;
   import wb_arbiter_pkg::*;

   logic       alu_valid_i;
   logic       alu_ready_o;
   RegAddrBus  alu_addr_i;
   RegBus      alu_data_i;

   logic       lsu_valid_i;
   RegAddrBus  lsu_addr_i;
   RegBus      lsu_data_i;
   logic [1:0] lsu_size_i;
   logic       lsu_sign_i;
   logic [1:0] lsu_offset_i;

   logic       wen_o;
   RegAddrBus  wr_addr_o;
   RegBus      wr_data_o;

   RegAddrBus  hz_addr_i;
   logic       hz_hit_o;

   modport master (
      output alu_valid_i, alu_addr_i, alu_data_i,
      output lsu_valid_i, lsu_addr_i, lsu_data_i, lsu_size_i, lsu_sign_i, lsu_offset_i,
      output hz_addr_i,
      input  alu_ready_o, wen_o, wr_addr_o, wr_data_o, hz_hit_o
   );

   modport slave (
      input  alu_valid_i, alu_addr_i, alu_data_i,
      input  lsu_valid_i, lsu_addr_i, lsu_data_i, lsu_size_i, lsu_sign_i, lsu_offset_i,
      input  hz_addr_i,
      output alu_ready_o, wen_o, wr_addr_o, wr_data_o, hz_hit_o
   );

endinterface

// File: rtl/wb_arbiter_ldfmt.sv
// Load data formatter: extracts the addressed byte/half from a 32-bit load
// return and sign- or zero-extends it. Purely combinational.
module wb_ldfmt
   import wb_arbiter_pkg::*;
(
   input  RegBus      data,
   input  logic [1:0] size,
   input  logic       sign,
   input  logic [1:0] offset,
   output RegBus      result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Lane select and extension; size code 11 falls through to word.
   always_comb begin
      byte_lane = data[{offset, 3'b000} +: 8];
      half_lane = offset[1] ? data[31:16] : data[15:0];
      result    = data;
      case (size)
         LS_BYTE: result = {{24{sign & byte_lane[7]}}, byte_lane};
         LS_HALF: result = {{16{sign & half_lane[15]}}, half_lane};
         LS_WORD: result = data;
         default: result = data;
      endcase
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the LSU load return (strict priority, never
// stalled) and the ALU result stream onto the single register file write
// port. ALU results that lose arbitration wait in a small in-order FIFO.
// The selected write is registered, so wen_o follows selection by a cycle.
module wb_arbiter #(
   parameter int FIFO_DEPTH = 2
) (
   input logic        clk,
   input logic        rstn,
   wb_arbiter_if.slave bus
);
   import wb_arbiter_pkg::*;

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   wr_t             fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            enq;
   logic            ready;
   RegBus           lsu_fmt;
   wr_t             alu_wr;
   wr_t             sel;
   logic            sel_valid;
   logic            fifo_hit;
   logic [PW-1:0]   rel;
   logic            wen_r;
   RegAddrBus       addr_r;
   RegBus           data_r;

   wb_ldfmt u_ldfmt (
      .data   (bus.lsu_data_i),
      .size   (bus.lsu_size_i),
      .sign   (bus.lsu_sign_i),
      .offset (bus.lsu_offset_i),
      .result (lsu_fmt)
   );

   // Ready depends only on occupancy, so a full FIFO refuses a push even in
   // a cycle where it also drains an entry. Held low throughout reset.
   assign full   = (count == DEPTH_C);
   assign empty  = (count == '0);
   assign ready  = ~rstn & ~full;
   assign push   = bus.alu_valid_i & ready;
   assign alu_wr = {bus.alu_addr_i, bus.alu_data_i};

   // Per-cycle selection: LSU, else FIFO head, else bypass the ALU push.
   always_comb begin
      sel_valid = 1'b0;
      sel       = '0;
      pop       = 1'b0;
      enq       = 1'b0;
      if (bus.lsu_valid_i) begin
         sel_valid = 1'b1;
         sel       = {bus.lsu_addr_i, lsu_fmt};
         enq       = push;
      end else if (!empty) begin
         sel_valid = 1'b1;
         sel       = fifo_mem[rd_ptr];
         pop       = 1'b1;
         enq       = push;
      end else if (push) begin
         sel_valid = 1'b1;
         sel       = alu_wr;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (enq && !pop)      count <= count + CW'(1);
         else if (pop && !enq) count <= count - CW'(1);
      end
   end

   // FIFO storage; contents are only meaningful inside the occupied window.
   always_ff @(posedge clk) begin
      if (enq) fifo_mem[wr_ptr] <= alu_wr;
   end

   // Output register; address-0 writes are consumed but never enabled.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         wen_r  <= 1'b0;
         addr_r <= ZeroRegAddr;
         data_r <= '0;
      end else begin
         wen_r <= sel_valid && (sel.addr != ZeroRegAddr);
         if (sel_valid) begin
            addr_r <= sel.addr;
            data_r <= sel.data;
         end
      end
   end

   // Hazard scan over the occupied FIFO window (offset from rd_ptr < count).
   always_comb begin
      fifo_hit = 1'b0;
      rel      = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         rel = PW'(i) - rd_ptr;
         if (({1'b0, rel} < count) && (fifo_mem[i].addr == bus.hz_addr_i))
            fifo_hit = 1'b1;
      end
   end

   assign bus.alu_ready_o = ready;
   assign bus.wen_o       = wen_r;
   assign bus.wr_addr_o   = addr_r;
   assign bus.wr_data_o   = data_r;
   assign bus.hz_hit_o    = ~rstn && (bus.hz_addr_i != ZeroRegAddr) &&
                            (fifo_hit || (wen_r && (addr_r == bus.hz_addr_i)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a constant vector table for the basic cases, hand
// sequences for burst back-pressure and mid-operation reset, then random
// traffic checked against a queue-based reference model.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int DEPTH = 2;

   typedef struct {
      logic        alu_valid;
      logic [4:0]  alu_addr;
      logic [31:0] alu_data;
      logic        lsu_valid;
      logic [4:0]  lsu_addr;
      logic [31:0] lsu_data;
      logic [1:0]  lsu_size;
      logic        lsu_sign;
      logic [1:0]  lsu_offset;
      logic [4:0]  hz_addr;
   } in_t;

   typedef struct {
      in_t         i;
      logic        e_rdy;
      logic        e_hz;
      logic        e_wen;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
   } vec_t;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } mw_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   wb_arbiter_if bus ();

   wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: pending ALU writes in arrival order, plus the write
   // that the port should be presenting this cycle.
   mw_t m_q[$];
   logic m_wen = 1'b0;
   mw_t  m_out = '0;

   logic        o_rdy, o_hz, o_wen;
   logic [4:0]  o_addr;
   logic [31:0] o_data;
   logic [36:0] exp_q[$];
   vec_t        tbl[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_fmt(logic [31:0] d, logic [1:0] sz, logic sg, logic [1:0] off);
      logic [31:0] v;
      case (sz)
         2'b00: begin
            v = (d >> (int'(off) * 8)) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
         end
         2'b01: begin
            v = (d >> (off[1] ? 16 : 0)) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
         end
         default: v = d;
      endcase
      return v;
   endfunction

   function automatic in_t mk_in(logic av, logic [4:0] aa, logic [31:0] ad,
                                 logic lv, logic [4:0] la, logic [31:0] ld,
                                 logic [1:0] ls, logic lg, logic [1:0] lo, logic [4:0] hz);
      in_t x;
      x.alu_valid = av; x.alu_addr = aa; x.alu_data = ad;
      x.lsu_valid = lv; x.lsu_addr = la; x.lsu_data = ld;
      x.lsu_size = ls;  x.lsu_sign = lg; x.lsu_offset = lo;
      x.hz_addr = hz;
      return x;
   endfunction

   function automatic in_t idle_in(logic [4:0] hz);
      return mk_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 2'b10, 1'b0, 2'd0, hz);
   endfunction

   function automatic vec_t mk_vec(in_t i, logic r, logic h, logic w, logic [4:0] a, logic [31:0] d);
      vec_t v;
      v.i = i; v.e_rdy = r; v.e_hz = h; v.e_wen = w; v.e_addr = a; v.e_data = d;
      return v;
   endfunction

   task automatic drive(input in_t i);
      bus.alu_valid_i  = i.alu_valid;
      bus.alu_addr_i   = i.alu_addr;
      bus.alu_data_i   = i.alu_data;
      bus.lsu_valid_i  = i.lsu_valid;
      bus.lsu_addr_i   = i.lsu_addr;
      bus.lsu_data_i   = i.lsu_data;
      bus.lsu_size_i   = i.lsu_size;
      bus.lsu_sign_i   = i.lsu_sign;
      bus.lsu_offset_i = i.lsu_offset;
      bus.hz_addr_i    = i.hz_addr;
   endtask

   // One clock cycle: called at a falling edge, drives inputs, checks the
   // combinational outputs against the model, advances the model, then
   // checks the registered write just after the rising edge.
   task automatic step(input in_t i);
      logic e_rdy, e_hz, push, have, took;
      mw_t  sel, a;
      drive(i);
      #1;
      e_rdy = (m_q.size() < DEPTH);
      e_hz  = 1'b0;
      if (i.hz_addr != 5'd0) begin
         foreach (m_q[k]) if (m_q[k].addr == i.hz_addr) e_hz = 1'b1;
         if (m_wen && m_out.addr == i.hz_addr) e_hz = 1'b1;
      end
      o_rdy = bus.alu_ready_o;
      o_hz  = bus.hz_hit_o;
      check("model_ready", o_rdy, e_rdy);
      check("model_hz", o_hz, e_hz);
      push   = i.alu_valid && e_rdy;
      a.addr = i.alu_addr;
      a.data = i.alu_data;
      sel    = '0;
      have   = 1'b0;
      took   = 1'b0;
      if (i.lsu_valid) begin
         sel.addr = i.lsu_addr;
         sel.data = ref_fmt(i.lsu_data, i.lsu_size, i.lsu_sign, i.lsu_offset);
         have = 1'b1;
      end else if (m_q.size() > 0) begin
         sel  = m_q.pop_front();
         have = 1'b1;
      end else if (push) begin
         sel  = a;
         have = 1'b1;
         took = 1'b1;
      end
      if (push && !took) m_q.push_back(a);
      m_wen = have && (sel.addr != 5'd0);
      if (have) m_out = sel;
      @(posedge clk);
      #1;
      o_wen  = bus.wen_o;
      o_addr = bus.wr_addr_o;
      o_data = bus.wr_data_o;
      check("model_wen", o_wen, m_wen);
      if (m_wen) begin
         check("model_addr", o_addr, m_out.addr);
         check("model_data", o_data, m_out.data);
      end
      @(negedge clk);
   endtask

   // Reset for a few cycles with a live hazard query; every output must read 0.
   task automatic apply_reset(input logic [4:0] hz, input int cycles);
      drive(idle_in(hz));
      rstn = 1'b1;
      m_q.delete();
      m_wen = 1'b0;
      #1;
      check("rst_wen", bus.wen_o, 0);
      check("rst_addr", bus.wr_addr_o, 0);
      check("rst_data", bus.wr_data_o, 0);
      check("rst_ready", bus.alu_ready_o, 0);
      check("rst_hz", bus.hz_hit_o, 0);
      repeat (cycles) @(negedge clk);
      check("rst_hold_wen", bus.wen_o, 0);
      check("rst_hold_ready", bus.alu_ready_o, 0);
      rstn = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      // ---------------- reset ----------------
      rstn = 1'b1;
      drive(idle_in(5'd0));
      @(negedge clk);
      apply_reset(5'd1, 2);

      // ---------------- vector table ----------------
      tbl[0]  = mk_vec(mk_in(1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'h0, 2'b10, 0, 2'd0, 5'd0),  1, 0, 1, 5'd5,  32'h1234_5678);
      tbl[1]  = mk_vec(idle_in(5'd5),                                                         1, 1, 0, 5'd0,  32'h0);
      tbl[2]  = mk_vec(mk_in(1, 5'd7, 32'hA, 1, 5'd3, 32'h0000_80FF, 2'b00, 1, 2'd0, 5'd0),  1, 0, 1, 5'd3,  32'hFFFF_FFFF);
      tbl[3]  = mk_vec(idle_in(5'd7),                                                         1, 1, 1, 5'd7,  32'h0000_000A);
      tbl[4]  = mk_vec(mk_in(0, 5'd0, 32'h0, 1, 5'd9, 32'hBEEF_1234, 2'b01, 0, 2'd2, 5'd7),  1, 1, 1, 5'd9,  32'h0000_BEEF);
      tbl[5]  = mk_vec(mk_in(1, 5'd0, 32'h55, 0, 5'd0, 32'h0, 2'b10, 0, 2'd0, 5'd0),         1, 0, 0, 5'd0,  32'h0);
      tbl[6]  = mk_vec(idle_in(5'd9),                                                         1, 0, 0, 5'd0,  32'h0);
      tbl[7]  = mk_vec(mk_in(0, 5'd0, 32'h0, 1, 5'd4, 32'h1234_5678, 2'b00, 1, 2'd3, 5'd0),  1, 0, 1, 5'd4,  32'h0000_0012);
      tbl[8]  = mk_vec(mk_in(0, 5'd0, 32'h0, 1, 5'd6, 32'h0000_ABCD, 2'b01, 1, 2'd0, 5'd4),  1, 1, 1, 5'd6,  32'hFFFF_ABCD);
      tbl[9]  = mk_vec(mk_in(0, 5'd0, 32'h0, 1, 5'd8, 32'hCAFE_F00D, 2'b11, 1, 2'd1, 5'd0),  1, 0, 1, 5'd8,  32'hCAFE_F00D);
      tbl[10] = mk_vec(mk_in(0, 5'd0, 32'h0, 1, 5'd10, 32'h0000_F000, 2'b00, 0, 2'd1, 5'd0), 1, 0, 1, 5'd10, 32'h0000_00F0);
      tbl[11] = mk_vec(mk_in(1, 5'd13, 32'h13, 1, 5'd12, 32'h8000_0000, 2'b10, 1, 2'd0, 5'd13), 1, 0, 1, 5'd12, 32'h8000_0000);
      tbl[12] = mk_vec(idle_in(5'd13),                                                        1, 1, 1, 5'd13, 32'h0000_0013);

      for (int v = 0; v < 13; v++) begin
         step(tbl[v].i);
         check($sformatf("tbl%0d_ready", v), o_rdy, tbl[v].e_rdy);
         check($sformatf("tbl%0d_hz", v), o_hz, tbl[v].e_hz);
         check($sformatf("tbl%0d_wen", v), o_wen, tbl[v].e_wen);
         if (tbl[v].e_wen) begin
            check($sformatf("tbl%0d_addr", v), o_addr, tbl[v].e_addr);
            check($sformatf("tbl%0d_data", v), o_data, tbl[v].e_data);
         end
      end

      // ---------------- LSU burst against continuous ALU pushes ----------------
      for (int k = 0; k < 4; k++) exp_q.push_back({5'(17 + k), 32'h1000_0000 + 32'(k)});
      for (int k = 0; k < 3; k++) exp_q.push_back({5'(21 + k), 32'hA000_0000 + 32'(k)});
      begin
         int alu_idx;
         in_t x;
         alu_idx = 0;
         for (int c = 0; c < 12; c++) begin
            x = idle_in(5'd0);
            if (c < 4) begin
               x.lsu_valid = 1'b1;
               x.lsu_addr  = 5'(17 + c);
               x.lsu_data  = 32'h1000_0000 + 32'(c);
               x.lsu_size  = 2'b10;
            end
            if (alu_idx < 3) begin
               x.alu_valid = 1'b1;
               x.alu_addr  = 5'(21 + alu_idx);
               x.alu_data  = 32'hA000_0000 + 32'(alu_idx);
            end
            step(x);
            if (x.alu_valid && o_rdy) alu_idx++;
            if (c == 2 || c == 3) check("burst_ready_blocked", o_rdy, 0);
            if (o_wen) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL burst_extra_write: got %0h expected no write", {o_addr, o_data});
               end else begin
                  check("burst_order", {o_addr, o_data}, exp_q.pop_front());
               end
            end
         end
         check("burst_drained", exp_q.size(), 0);
      end

      // ---------------- reset with two buffered entries ----------------
      step(mk_in(1, 5'd2, 32'h22, 1, 5'd1, 32'h11, 2'b10, 0, 2'd0, 5'd0));
      step(mk_in(1, 5'd4, 32'h44, 1, 5'd3, 32'h33, 2'b10, 0, 2'd0, 5'd2));
      check("prefill_full", bus.alu_ready_o, 0);
      apply_reset(5'd2, 2);
      step(idle_in(5'd4));
      check("post_rst_ready", o_rdy, 1);
      check("post_rst_hz", o_hz, 0);
      for (int c = 0; c < 4; c++) begin
         step(idle_in(5'd2));
         check("post_rst_wen", o_wen, 0);
      end

      // ---------------- random traffic ----------------
      for (int c = 0; c < 400; c++) begin
         in_t x;
         x.alu_valid  = ($urandom_range(0, 9) < 6);
         x.alu_addr   = 5'($urandom_range(0, 31));
         x.alu_data   = $urandom;
         x.lsu_valid  = ($urandom_range(0, 9) < 3);
         x.lsu_addr   = 5'($urandom_range(0, 31));
         x.lsu_data   = $urandom;
         x.lsu_size   = 2'($urandom_range(0, 3));
         x.lsu_sign   = 1'($urandom_range(0, 1));
         x.lsu_offset = 2'($urandom_range(0, 3));
         x.hz_addr    = 5'($urandom_range(0, 31));
         step(x);
         if (c == 200) apply_reset(x.alu_addr, 1);
      end
      for (int c = 0; c < 4; c++) step(idle_in(5'($urandom_range(0, 31))));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
